mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_rr_pick2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding, requester identities and the fixed word size code.
package mem_port_arbiter_pkg;

   // Transaction phases of the shared memory port.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arbState_e;

   // Requester identities; also used as the round-robin history value.
   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   // Size code for a full 32-bit word; instruction fetches always use it.
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Byte-enable pattern for a transaction that writes nothing.
   localparam logic [3:0] WEN_NONE = 4'b0000;

   // The requester that did not receive the given grant.
   function automatic logic otherOwner(input logic owner);
      return (owner == OWN_INST) ? OWN_DATA : OWN_INST;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-input round-robin picker. A lone requester always wins; on a tie the
// requester that was not granted last time wins.
module rr_pick2
   import mem_port_arbiter_pkg::*;
(
   input  logic reqInst,
   input  logic reqData,
   input  logic lastGrant,
   output logic grantValid,
   output logic grantOwner
);

   // Pick the winner from the request pair and the grant history.
   always_comb begin
      grantValid = reqInst | reqData;
      grantOwner = OWN_INST;
      if (reqInst && reqData) begin
         grantOwner = otherOwner(lastGrant);
      end else if (reqData) begin
         grantOwner = OWN_DATA;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one request/response memory port between the instruction fetch
// path and the load/store path. One transaction is in flight at a time:
// IDLE picks a winner and latches its request, ADDR presents it until the
// memory accepts the address, DATA waits for the response and then pulses
// the owner's ready for one cycle.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_ready,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [3:0]        data_wen,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_ready,

   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [3:0]        mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic              stall_o
);

   arbState_e         stateReg;
   arbState_e         stateNext;

   // Latched request of the transaction in flight.
   logic              ownerReg;
   logic              wrReg;
   logic [1:0]        sizeReg;
   logic [3:0]        wenReg;
   logic [ADDR_W-1:0] addrReg;
   logic [DATA_W-1:0] wdataReg;

   // Round-robin history: owner of the most recent grant.
   logic              lastGrantReg;

   // Per-requester response registers.
   logic [DATA_W-1:0] instRdataReg;
   logic [DATA_W-1:0] dataRdataReg;
   logic              instReadyReg;
   logic              dataReadyReg;

   // Arbitration and FSM strobes.
   logic              instElig;
   logic              dataElig;
   logic              grantValid;
   logic              grantOwner;
   logic              takeGrant;
   logic              finishXfer;
   logic              memReqNext;

   // A requester seeing its ready this cycle is still showing the request
   // that just completed, so it sits out this round of arbitration.
   assign instElig = inst_req & ~instReadyReg;
   assign dataElig = data_req & ~dataReadyReg;

   rr_pick2 picker (
      .reqInst    (instElig),
      .reqData    (dataElig),
      .lastGrant  (lastGrantReg),
      .grantValid (grantValid),
      .grantOwner (grantOwner)
   );

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateReg <= IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Next-state logic and per-cycle strobes; memory handshakes are only
   // honoured in the phase that expects them.
   always_comb begin
      stateNext  = stateReg;
      takeGrant  = 1'b0;
      finishXfer = 1'b0;
      memReqNext = 1'b0;
      case (stateReg)
         IDLE: begin
            if (grantValid) begin
               takeGrant = 1'b1;
               stateNext = ADDR;
            end
         end
         ADDR: begin
            memReqNext = 1'b1;
            if (mem_addr_ok) begin
               stateNext = DATA;
            end
         end
         DATA: begin
            if (mem_data_ok) begin
               finishXfer = 1'b1;
               stateNext  = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Capture the winner's request so the memory sees stable fields even if
   // the requester changes or drops its inputs mid-transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ownerReg     <= OWN_INST;
         lastGrantReg <= OWN_INST;
         wrReg        <= 1'b0;
         sizeReg      <= 2'b00;
         wenReg       <= WEN_NONE;
         addrReg      <= '0;
         wdataReg     <= '0;
      end else if (takeGrant) begin
         ownerReg     <= grantOwner;
         lastGrantReg <= grantOwner;
         if (grantOwner == OWN_DATA) begin
            wrReg    <= data_wr;
            sizeReg  <= data_size;
            wenReg   <= data_wen;
            addrReg  <= data_addr;
            wdataReg <= data_wdata;
         end else begin
            wrReg    <= 1'b0;
            sizeReg  <= SIZE_WORD;
            wenReg   <= WEN_NONE;
            addrReg  <= inst_addr;
            wdataReg <= '0;
         end
      end
   end

   // Route the response to its owner: readies pulse for one cycle, read
   // data is kept until that owner's next load or fetch completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instRdataReg <= '0;
         dataRdataReg <= '0;
         instReadyReg <= 1'b0;
         dataReadyReg <= 1'b0;
      end else begin
         instReadyReg <= 1'b0;
         dataReadyReg <= 1'b0;
         if (finishXfer) begin
            if (ownerReg == OWN_INST) begin
               instRdataReg <= mem_rdata;
               instReadyReg <= 1'b1;
            end else begin
               dataReadyReg <= 1'b1;
               if (!wrReg) begin
                  dataRdataReg <= mem_rdata;
               end
            end
         end
      end
   end

   // Memory port: request fields are forced to zero whenever no request
   // is being presented.
   assign mem_req   = memReqNext;
   assign mem_wr    = memReqNext & wrReg;
   assign mem_size  = memReqNext ? sizeReg  : 2'b00;
   assign mem_wen   = memReqNext ? wenReg   : WEN_NONE;
   assign mem_addr  = memReqNext ? addrReg  : '0;
   assign mem_wdata = memReqNext ? wdataReg : '0;

   assign inst_rdata = instRdataReg;
   assign inst_ready = instReadyReg;
   assign data_rdata = dataRdataReg;
   assign data_ready = dataReadyReg;

   // Stall while either path has a request that has not just completed.
   assign stall_o = (inst_req & ~instReadyReg) | (data_req & ~dataReadyReg);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a responding memory model, request
// queues for both requesters and a scoreboard of expected memory
// transactions in grant order.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_ready;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_ready;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;
   logic        stall_o;

   typedef struct {
      logic        owner;
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } xfer_t;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dreq_t;

   xfer_t       expMemQ[$];
   logic [31:0] instQ[$];
   dreq_t       dataQ[$];
   xfer_t       cur;

   int passCount = 0;
   int checkCount = 0;
   int cycle = 0;
   int rPhase = 0;
   int waitCnt = 0;
   int addrDelay = 0;
   int dataDelay = 0;
   int instPulses = 0;
   int dataPulses = 0;
   int firstInstRdyCycle = -1;
   int startCycle = 0;
   logic noise = 1'b0;
   logic dropInst = 1'b0;
   logic skipInstPop = 1'b0;
   logic expInstRdy = 1'b0;
   logic expDataRdy = 1'b0;
   logic pendInstRdy = 1'b0;
   logic pendDataRdy = 1'b0;
   logic pendInstCap = 1'b0;
   logic pendDataCap = 1'b0;
   logic [31:0] pendRdata = '0;
   logic [31:0] expInstRdata = '0;
   logic [31:0] expDataRdata = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_rdata  (inst_rdata),
      .inst_ready  (inst_ready),
      .data_req    (data_req),
      .data_wr     (data_wr),
      .data_size   (data_size),
      .data_wen    (data_wen),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_rdata  (data_rdata),
      .data_ready  (data_ready),
      .mem_req     (mem_req),
      .mem_wr      (mem_wr),
      .mem_size    (mem_size),
      .mem_wen     (mem_wen),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_addr_ok (mem_addr_ok),
      .mem_data_ok (mem_data_ok),
      .mem_rdata   (mem_rdata),
      .stall_o     (stall_o)
   );

   function automatic logic [31:0] memModel(input logic [31:0] a);
      if (a == 32'hBFC0_0000) return 32'h3C08_BFAF;
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      assert (got === exp) passCount++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic expectInst(input logic [31:0] a);
      xfer_t x;
      x.owner = OWN_INST; x.wr = 1'b0; x.size = 2'b10; x.wen = 4'b0000;
      x.addr = a; x.wdata = '0; x.rdata = memModel(a);
      expMemQ.push_back(x);
   endtask

   task automatic expectData(input logic wr, input logic [1:0] sz, input logic [3:0] wen,
                             input logic [31:0] a, input logic [31:0] wd);
      xfer_t x;
      x.owner = OWN_DATA; x.wr = wr; x.size = sz; x.wen = wen;
      x.addr = a; x.wdata = wd; x.rdata = memModel(a);
      expMemQ.push_back(x);
   endtask

   task automatic reqData(input logic wr, input logic [1:0] sz, input logic [3:0] wen,
                          input logic [31:0] a, input logic [31:0] wd);
      dreq_t d;
      d.wr = wr; d.size = sz; d.wen = wen; d.addr = a; d.wdata = wd;
      dataQ.push_back(d);
   endtask

   task automatic driveReqs();
      inst_req  = (instQ.size() > 0);
      inst_addr = inst_req ? instQ[0] : '0;
      data_req  = (dataQ.size() > 0);
      if (data_req) begin
         data_wr = dataQ[0].wr; data_size = dataQ[0].size; data_wen = dataQ[0].wen;
         data_addr = dataQ[0].addr; data_wdata = dataQ[0].wdata;
      end else begin
         data_wr = 1'b0; data_size = 2'b00; data_wen = 4'b0000;
         data_addr = '0; data_wdata = '0;
      end
   endtask

   // One clock: compare outputs, play the memory, update the requesters.
   task automatic tick();
      logic prevInstRdy;
      logic prevDataRdy;
      logic ownerPrevRdy;
      @(posedge clk);
      #1;
      cycle++;
      prevInstRdy = expInstRdy;
      prevDataRdy = expDataRdy;
      expInstRdy  = pendInstRdy;
      expDataRdy  = pendDataRdy;
      if (pendInstCap) expInstRdata = pendRdata;
      if (pendDataCap) expDataRdata = pendRdata;
      pendInstRdy = 1'b0; pendDataRdy = 1'b0; pendInstCap = 1'b0; pendDataCap = 1'b0;

      if (inst_ready === 1'b1) begin
         instPulses++;
         if (firstInstRdyCycle < 0) firstInstRdyCycle = cycle;
      end
      if (data_ready === 1'b1) dataPulses++;
      check("inst_ready", inst_ready, expInstRdy);
      check("data_ready", data_ready, expDataRdy);
      check("inst_rdata", inst_rdata, expInstRdata);
      check("data_rdata", data_rdata, expDataRdata);
      check("stall_o", stall_o, (inst_req & ~expInstRdy) | (data_req & ~expDataRdy));
      if (mem_req !== 1'b1) begin
         check("mem_addr_idle_zero", mem_addr, 0);
         check("mem_ctl_idle_zero", {mem_wr, mem_size, mem_wen, mem_wdata}, 0);
      end

      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = $urandom;
      if (rPhase == 0) begin
         if (mem_req === 1'b1) begin
            if (expMemQ.size() == 0) begin
               check("unexpected_mem_req", mem_req, 0);
            end else begin
               cur = expMemQ.pop_front();
               rPhase = 1;
               waitCnt = addrDelay;
               ownerPrevRdy = (cur.owner == OWN_INST) ? prevInstRdy : prevDataRdy;
               check("grant_in_own_ready", mem_req & ownerPrevRdy, 0);
               if (cur.owner == OWN_INST && dropInst && instQ.size() > 0) begin
                  instQ.delete(0);
                  skipInstPop = 1'b1;
                  dropInst = 1'b0;
               end
            end
         end else if (noise) begin
            mem_data_ok = 1'b1;
            mem_addr_ok = 1'($urandom_range(0, 1));
         end
      end
      if (rPhase == 1) begin
         check("mem_req", mem_req, 1);
         check("mem_addr", mem_addr, cur.addr);
         check("mem_wr", mem_wr, cur.wr);
         check("mem_size", mem_size, cur.size);
         check("mem_wen", mem_wen, cur.wen);
         check("mem_wdata", mem_wdata, cur.wdata);
         if (waitCnt == 0) begin
            mem_addr_ok = 1'b1;
            rPhase = 2;
            waitCnt = dataDelay;
         end else begin
            waitCnt--;
            if (noise) mem_data_ok = 1'b1;
         end
      end else if (rPhase == 2) begin
         check("mem_req_in_data", mem_req, 0);
         if (waitCnt == 0) begin
            mem_data_ok = 1'b1;
            mem_rdata   = cur.rdata;
            pendRdata   = cur.rdata;
            pendInstRdy = (cur.owner == OWN_INST);
            pendDataRdy = (cur.owner == OWN_DATA);
            pendInstCap = (cur.owner == OWN_INST);
            pendDataCap = (cur.owner == OWN_DATA) && !cur.wr;
            rPhase = 0;
            $display("xfer %s addr=%h wr=%0d wen=%b wdata=%h rdata=%h",
                     (cur.owner == OWN_INST) ? "inst" : "data", cur.addr, cur.wr,
                     cur.wen, cur.wdata, cur.rdata);
         end else begin
            waitCnt--;
            if (noise) mem_addr_ok = 1'b1;
         end
      end

      if (expInstRdy) begin
         if (skipInstPop) skipInstPop = 1'b0;
         else if (instQ.size() > 0) instQ.delete(0);
      end
      if (expDataRdy && dataQ.size() > 0) dataQ.delete(0);
      driveReqs();
   endtask

   task automatic drain(input int maxCycles);
      int n;
      n = 0;
      while ((instQ.size() > 0 || dataQ.size() > 0 || expMemQ.size() > 0 || rPhase != 0 ||
              pendInstRdy || pendDataRdy) && n < maxCycles) begin
         tick();
         n++;
      end
      check("pending_xfers_after_drain", expMemQ.size(), 0);
      check("pending_reqs_after_drain", instQ.size() + dataQ.size(), 0);
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
      driveReqs();
      @(posedge clk);
      #1;
      check("reset_mem_req", mem_req, 0);
      check("reset_mem_addr", mem_addr, 0);
      check("reset_inst_ready", inst_ready, 0);
      check("reset_data_ready", data_ready, 0);
      check("reset_inst_rdata", inst_rdata, 0);
      check("reset_data_rdata", data_rdata, 0);
      check("reset_stall", stall_o, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // Simultaneous requests after reset: data wins the first tie.
      reqData(1'b0, 2'b10, 4'b0000, 32'h8000_1000, 32'h0);
      instQ.push_back(32'hBFC0_0004);
      expectData(1'b0, 2'b10, 4'b0000, 32'h8000_1000, 32'h0);
      expectInst(32'hBFC0_0004);
      driveReqs();
      drain(60);

      // Minimum-latency boot fetch.
      firstInstRdyCycle = -1;
      startCycle = cycle;
      instQ.push_back(32'hBFC0_0000);
      expectInst(32'hBFC0_0000);
      driveReqs();
      drain(40);
      check("fetch_latency", firstInstRdyCycle - startCycle, 3);
      check("fetch_rdata", inst_rdata, 32'h3C08_BFAF);

      // Store with slow address accept and stray responses while waiting.
      addrDelay = 3; noise = 1'b1; dataPulses = 0;
      reqData(1'b1, 2'b01, 4'b0011, 32'h8000_0010, 32'h0000_BEEF);
      expectData(1'b1, 2'b01, 4'b0011, 32'h8000_0010, 32'h0000_BEEF);
      driveReqs();
      drain(60);
      check("store_ready_pulses", dataPulses, 1);
      check("store_keeps_rdata", data_rdata, memModel(32'h8000_1000));

      // Fetch request withdrawn while its address phase is still waiting.
      addrDelay = 2; noise = 1'b0; dropInst = 1'b1; instPulses = 0;
      instQ.push_back(32'hBFC0_0100);
      expectInst(32'hBFC0_0100);
      driveReqs();
      drain(60);
      check("dropped_fetch_pulses", instPulses, 1);
      check("dropped_fetch_stall", stall_o, 0);

      // Both requesters held for six transactions: grants alternate.
      addrDelay = 0; dataDelay = 1; noise = 1'b1;
      for (int i = 0; i < 3; i++) begin
         reqData(i[0], 2'b10, i[0] ? 4'b1111 : 4'b0000, 32'h8000_0100 + 32'(i * 4),
                 32'hCAFE_0000 + 32'(i));
         instQ.push_back(32'hBFC0_0200 + 32'(i * 4));
      end
      for (int i = 0; i < 3; i++) begin
         expectData(i[0], 2'b10, i[0] ? 4'b1111 : 4'b0000, 32'h8000_0100 + 32'(i * 4),
                    32'hCAFE_0000 + 32'(i));
         expectInst(32'hBFC0_0200 + 32'(i * 4));
      end
      driveReqs();
      drain(120);

      // Reset while a load waits for its response.
      dataDelay = 3; dataPulses = 0;
      reqData(1'b0, 2'b10, 4'b0000, 32'h8000_2000, 32'h0);
      expectData(1'b0, 2'b10, 4'b0000, 32'h8000_2000, 32'h0);
      driveReqs();
      for (int i = 0; i < 20 && rPhase != 2; i++) tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("midreset_mem_req", mem_req, 0);
      check("midreset_mem_addr", mem_addr, 0);
      check("midreset_data_ready", data_ready, 0);
      check("midreset_inst_ready", inst_ready, 0);
      check("midreset_data_rdata", data_rdata, 0);
      check("midreset_inst_rdata", inst_rdata, 0);
      instQ.delete(); dataQ.delete(); expMemQ.delete();
      rPhase = 0; waitCnt = 0; skipInstPop = 1'b0; dropInst = 1'b0;
      expInstRdy = 1'b0; expDataRdy = 1'b0;
      pendInstRdy = 1'b0; pendDataRdy = 1'b0; pendInstCap = 1'b0; pendDataCap = 1'b0;
      expInstRdata = '0; expDataRdata = '0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      driveReqs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("midreset_no_pulse", dataPulses, 0);

      // First grant after reset again favours data on a tie.
      dataDelay = 0; noise = 1'b0;
      reqData(1'b0, 2'b10, 4'b0000, 32'h8000_3000, 32'h0);
      instQ.push_back(32'hBFC0_0300);
      expectData(1'b0, 2'b10, 4'b0000, 32'h8000_3000, 32'h0);
      expectInst(32'hBFC0_0300);
      driveReqs();
      drain(60);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
